// File: rtl/async_receiver_pkg.sv
// Shared widths, defaults and FSM state encodings for the serial frame receiver.
// The state encoding is visible on the debug port, so it is fixed here.
package async_receiver_pkg;

    localparam int FRAME_BITS         = 72;
    localparam int CMD_BITS           = 8;
    localparam int DATA_BITS_W        = 64;
    localparam int DEFAULT_BIT_CYCLES = 10;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_DATA     = 3'd2,
        ST_TRAILER  = 3'd3,
        ST_STOP     = 3'd4,
        ST_WAIT_LOW = 3'd5
    } rx_state_t;

endpackage

// File: rtl/async_receiver_if.sv
// Word-delivery side of the receiver: valid/ack handshake plus status flags.
// The receiver drives through the master modport; the consumer uses slave.
interface async_receiver_if;
    import async_receiver_pkg::*;

    logic                   out_valid;
    logic                   out_ack;
    logic [CMD_BITS-1:0]    command;
    logic [DATA_BITS_W-1:0] data;
    logic                   framing_error;
    logic                   overflow;

    modport master (
        output out_valid, command, data, framing_error, overflow,
        input  out_ack
    );

    modport slave (
        input  out_valid, command, data, framing_error, overflow,
        output out_ack
    );

endinterface

// File: rtl/async_receiver_line_synchroniser.sv
// Brings the asynchronous serial line into the clk domain and flags rising edges.
// Only the last synchroniser stage is ever used for line decisions.
module async_receiver_line_synchroniser #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rxd,
    output logic rxd_sync,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   rxd_prev_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_reg     <= '0;
            rxd_prev_reg <= 1'b0;
        end else begin
            sync_reg     <= {sync_reg[SYNC_STAGES-2:0], rxd};
            rxd_prev_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign rxd_sync = sync_reg[SYNC_STAGES-1];
    assign rise     = rxd_sync & ~rxd_prev_reg;

endmodule

// File: rtl/async_receiver.sv
// Serial frame receiver: start-edge bit timing recovery, framing checks and
// delivery of {command, data} words on a valid/ack handshake.
module async_receiver
    import async_receiver_pkg::*;
#(
    parameter int BIT_CYCLES   = DEFAULT_BIT_CYCLES,
    parameter int SAMPLE_POINT = 5,
    parameter int DATA_BITS    = 72,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    RxD,
    async_receiver_if.master        rx_bus,
    output logic [3:0]              debug
);

    localparam int               CNT_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SAMPLE_AT  = CNT_W'(SAMPLE_POINT);
    localparam logic [CNT_W-1:0] LAST_PHASE = CNT_W'(BIT_CYCLES - 1);
    localparam logic [6:0]       LAST_SHIFT = 7'(DATA_BITS - 1);

    logic rxd_sync;
    logic rise;

    async_receiver_line_synchroniser #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_line_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .rxd      (RxD),
        .rxd_sync (rxd_sync),
        .rise     (rise)
    );

    rx_state_t             state_reg, state_next;
    logic [CNT_W-1:0]      bit_cnt_reg, bit_cnt_next;
    logic [6:0]            shift_cnt_reg, shift_cnt_next;
    logic [FRAME_BITS-1:0] shreg_reg, shreg_next;
    logic                  deliver;
    logic                  frame_err;
    logic                  sample;
    logic [CNT_W-1:0]      phase_inc;

    assign sample    = (bit_cnt_reg == SAMPLE_AT);
    assign phase_inc = (bit_cnt_reg == LAST_PHASE) ? '0 : bit_cnt_reg + CNT_W'(1);

    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = phase_inc;
        shift_cnt_next = shift_cnt_reg;
        shreg_next     = shreg_reg;
        deliver        = 1'b0;
        frame_err      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // The edge cycle itself is phase 0 of the start bit.
                bit_cnt_next = '0;
                if (rise) begin
                    state_next   = ST_START;
                    bit_cnt_next = CNT_W'(1);
                end
            end
            ST_START: begin
                if (sample) begin
                    if (rxd_sync) begin
                        state_next     = ST_DATA;
                        shift_cnt_next = '0;
                    end else begin
                        state_next   = ST_IDLE;
                        bit_cnt_next = '0;
                    end
                end
            end
            ST_DATA: begin
                if (sample) begin
                    shreg_next     = {shreg_reg[FRAME_BITS-2:0], rxd_sync};
                    shift_cnt_next = shift_cnt_reg + 7'd1;
                    if (shift_cnt_reg == LAST_SHIFT) begin
                        state_next = ST_TRAILER;
                    end
                end
            end
            ST_TRAILER: begin
                if (sample) begin
                    if (rxd_sync) begin
                        state_next = ST_STOP;
                    end else begin
                        frame_err    = 1'b1;
                        state_next   = ST_IDLE;
                        bit_cnt_next = '0;
                    end
                end
            end
            ST_STOP: begin
                if (sample) begin
                    bit_cnt_next = '0;
                    if (!rxd_sync) begin
                        deliver    = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        frame_err  = 1'b1;
                        state_next = ST_WAIT_LOW;
                    end
                end
            end
            ST_WAIT_LOW: begin
                // bit_cnt doubles as the run length of consecutive low clocks.
                if (rxd_sync) begin
                    bit_cnt_next = '0;
                end else if (bit_cnt_reg == LAST_PHASE) begin
                    state_next   = ST_IDLE;
                    bit_cnt_next = '0;
                end
            end
            default: begin
                state_next   = ST_IDLE;
                bit_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg              <= ST_IDLE;
            bit_cnt_reg            <= '0;
            shift_cnt_reg          <= '0;
            shreg_reg              <= '0;
            rx_bus.out_valid       <= 1'b0;
            rx_bus.command         <= '0;
            rx_bus.data            <= '0;
            rx_bus.framing_error   <= 1'b0;
            rx_bus.overflow        <= 1'b0;
        end else begin
            state_reg              <= state_next;
            bit_cnt_reg            <= bit_cnt_next;
            shift_cnt_reg          <= shift_cnt_next;
            shreg_reg              <= shreg_next;
            rx_bus.framing_error   <= frame_err;
            if (deliver) begin
                // A word still waiting for its ack wins over the new one.
                if (!rx_bus.out_valid || rx_bus.out_ack) begin
                    {rx_bus.command, rx_bus.data} <= shreg_reg;
                    rx_bus.out_valid              <= 1'b1;
                end else begin
                    rx_bus.overflow <= 1'b1;
                end
            end else if (rx_bus.out_ack) begin
                rx_bus.out_valid <= 1'b0;
            end
        end
    end

    assign debug = {rxd_sync, state_reg};

endmodule
